// File: rtl/uart_transmitter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_transmitter_if
// Description : Byte request / serial line bundle for the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_transmitter_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       TXD;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_data,
        output tx_start,
        input  TXD,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output TXD,
        output tx_busy,
        output tx_done
    );
endinterface
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : uart_transmitter
// Description : Start / 8 data (LSB first) / 1-2 stop UART frame serialiser.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset,
    uart_transmitter_if.slave bus
);

    localparam int c_BAUD_W = $clog2(CLKS_PER_BIT + 1);
    localparam int c_STOP_W = $clog2(2 * CLKS_PER_BIT + 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_STOP_W-1:0] c_STOP_LAST = c_STOP_W'(STOP_BITS * CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              r_state,    w_state_next;
    logic [c_BAUD_W-1:0] r_baud_cnt, w_baud_cnt_next;
    logic [c_STOP_W-1:0] r_stop_cnt, w_stop_cnt_next;
    logic [2:0]          r_bit_idx,  w_bit_idx_next;
    logic [7:0]          r_shift,    w_shift_next;
    logic                r_txd,      w_txd_next;
    logic                r_busy,     w_busy_next;
    logic                r_done,     w_done_next;
    logic [2:0]          w_bit_idx_inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_stop_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_cnt_next;
            r_stop_cnt <= w_stop_cnt_next;
            r_bit_idx  <= w_bit_idx_next;
            r_shift    <= w_shift_next;
            r_txd      <= w_txd_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
        end
    end

    assign w_bit_idx_inc = r_bit_idx + 3'd1;

    always_comb begin
        w_state_next    = r_state;
        w_baud_cnt_next = r_baud_cnt;
        w_stop_cnt_next = r_stop_cnt;
        w_bit_idx_next  = r_bit_idx;
        w_shift_next    = r_shift;
        w_txd_next      = r_txd;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_txd_next  = 1'b1;
                w_busy_next = 1'b0;
                if (bus.tx_start) begin
                    w_shift_next    = bus.tx_data;
                    w_state_next    = S_START;
                    w_txd_next      = 1'b0;
                    w_busy_next     = 1'b1;
                    w_baud_cnt_next = '0;
                end
            end
            S_START: begin
                if (r_baud_cnt == c_BAUD_LAST) begin
                    w_baud_cnt_next = '0;
                    w_bit_idx_next  = 3'd0;
                    w_state_next    = S_DATA;
                    w_txd_next      = r_shift[0];
                end else begin
                    w_baud_cnt_next = r_baud_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_baud_cnt == c_BAUD_LAST) begin
                    w_baud_cnt_next = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next    = S_STOP;
                        w_txd_next      = 1'b1;
                        w_stop_cnt_next = '0;
                    end else begin
                        w_bit_idx_next = w_bit_idx_inc;
                        w_txd_next     = r_shift[w_bit_idx_inc];
                    end
                end else begin
                    w_baud_cnt_next = r_baud_cnt + 1'b1;
                end
            end
            S_STOP: begin
                // Busy drops on the same edge the done pulse rises.
                if (r_stop_cnt == c_STOP_LAST) begin
                    w_state_next = S_IDLE;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b1;
                end else begin
                    w_stop_cnt_next = r_stop_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_txd_next   = 1'b1;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    assign bus.TXD     = r_txd;
    assign bus.tx_busy = r_busy;
    assign bus.tx_done = r_done;

endmodule
`default_nettype wire

// File: doc/uart_transmitter.md
# uart_transmitter

- Serialises one byte per request into an asynchronous UART frame on `TXD`: start bit, 8 data bits LSB first, then 1 or 2 stop bits.
- Sits directly upstream of the serial receiver, so its `TXD` drives the receiver's `RXD` in the serial loopback.
- Default timing of one clock per bit matches the receiver's one-sample-per-clock framing.
- Accepts bytes through a start/busy handshake and flags frame completion with a one-cycle pulse.

## Interface
- `CLKS_PER_BIT`, default 1: clock cycles per serial bit; legal range 1..65535.
- `STOP_BITS`, default 1: number of stop bits; legal values 1 or 2.
- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset; 0 = reset.
- `tx_data`  input  8  byte to send; sampled only at the accepting edge.
- `tx_start`  input  1  request; accepted at a rising edge where state is IDLE.
- `TXD`  output  1  serial line; idles high.
- `tx_busy`  output  1  high from the accepting edge until the frame's final edge.
- `tx_done`  output  1  one-cycle pulse at frame completion.

## Operation
- **States:** IDLE, START, DATA, STOP.
  - All outputs are registered.
  - `reset`=0 forces IDLE, `TXD`=1, `tx_busy`=0, `tx_done`=0, and clears all counters and the shift register, regardless of `clk`.
- **IDLE:** `TXD`=1, `tx_busy`=0.
  - If `tx_start`=1: latch `tx_data` into the shift register, go to START, set `TXD`=0 and `tx_busy`=1, clear the baud counter.
- **START:** holds `TXD`=0 for `CLKS_PER_BIT` cycles, then goes to DATA with bit index 0 and drives `TXD`=shift[0].
- **DATA:** each bit is held `CLKS_PER_BIT` cycles.
  - Bit index counts 0..7 and drives `TXD`=shift[index], LSB first.
  - After bit 7 completes: go to STOP, `TXD`=1.
- **STOP:** holds `TXD`=1 for `STOP_BITS*CLKS_PER_BIT` cycles.
  - Then go to IDLE, `tx_busy`=0, `tx_done`=1 for exactly one cycle.
- **Ignored inputs:**
  - `tx_start` in any non-IDLE state has no effect and is not queued.
  - `tx_data` changes after acceptance do not affect the frame in flight.
- **Back-to-back:** `tx_start` is accepted only in IDLE, so at least one idle-high cycle always separates consecutive frames. Holding `tx_start` high therefore sends consecutive frames with exactly one idle cycle between them.
- **Widths:**
  - Baud counter: `$clog2(CLKS_PER_BIT+1)` bits; wraps to 0 at `CLKS_PER_BIT`-1.
  - Stop counter covers `2*CLKS_PER_BIT`.
  - Bit index: 3 bits, no wrap beyond 7.
- **Reset mid-frame:** line returns high immediately, frame abandoned, no `tx_done`.
  - First request after release is accepted normally.

## Timing
- Accepting edge E (IDLE, `tx_start`=1): `TXD` is low in cycle E+1.
- With C=`CLKS_PER_BIT` and S=`STOP_BITS`:
  - Start bit occupies cycles E+1..E+C.
  - Data bit i occupies cycles E+1+(i+1)C..E+(i+2)C.
  - Stop bits follow.
- `tx_busy` is high for exactly (9+S)·C cycles. It falls at the same edge at which `tx_done` rises.
- Earliest next acceptance: the edge after `tx_busy` falls. Frame-to-frame period is (9+S)·C+1 cycles.
- Receiver compatibility (C=1, S=1): the stop cycle plus one idle cycle give the receiver its return-to-waiting cycle before the next start bit.

## Test plan
- **Single frame:** C=1, S=1, send 0xA5.
  - `TXD` over cycles E+1..E+10 = 0,1,0,1,0,0,1,0,1,1.
  - `tx_busy` high for exactly 10 cycles; `tx_done` pulses once, in the same cycle `tx_busy` falls.
- **Slow baud:** C=4, S=2, send 0x3C.
  - Each bit held exactly 4 cycles; stop high for 8 cycles.
  - `tx_busy` high for 44 cycles.
- **Busy protection:** C=1, send 0x81, then pulse `tx_start` with `tx_data`=0x7E mid-frame.
  - The line carries 0x81 only; no second frame starts.
  - `tx_data` changes during the frame leave the bits unchanged.
- **Reset mid-frame:** assert `reset`=0 asynchronously (between clock edges) during data bit 3.
  - `TXD`=1, `tx_busy`=0 immediately; no `tx_done`.
  - After release, 0x55 transmits correctly.
- **Loopback:** C=1, S=1, `TXD` wired to the receiver's `RXD`, `tx_start` held high.
  - Stream 0x5A, 0xFF, 0x00, 0x01.
  - Receiver `rx_data` equals each byte when its `rx_busy` falls.
  - Frames are 11 cycles apart with one idle cycle between them.
